// File: rtl/ewb_types_pkg.sv
// rtl/ewb_types_pkg.sv - shared types and default geometry for the eviction write buffer
package ewb_types_pkg;

    localparam int LINE_WIDTH  = 256;
    localparam int ADDR_WIDTH  = 32;
    localparam int OFFSET_BITS = 5;
    localparam int DRAIN_DELAY = 2;

    typedef logic [ADDR_WIDTH-OFFSET_BITS-1:0] line_addr_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_MEM_READ,
        ST_MEM_WRITE,
        ST_COOLDOWN
    } ewb_state_t;

endpackage

// File: rtl/ewb_entry.sv
// rtl/ewb_entry.sv - single buffered line: valid/line/data storage with hit compare
module ewb_entry #(
    parameter int LINE_WIDTH  = 256,
    parameter int LINE_ADDR_W = 27
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   capture,
    input  logic                   clear,
    input  logic [LINE_ADDR_W-1:0] cap_line,
    input  logic [LINE_WIDTH-1:0]  cap_data,
    input  logic [LINE_ADDR_W-1:0] lookup_line,
    output logic                   valid,
    output logic [LINE_ADDR_W-1:0] line,
    output logic [LINE_WIDTH-1:0]  data,
    output logic                   hit
);

    // Capture wins over clear; the controller never asks for both in one cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid <= 1'b0;
            line  <= '0;
            data  <= '0;
        end else if (capture) begin
            valid <= 1'b1;
            line  <= cap_line;
            data  <= cap_data;
        end else if (clear) begin
            valid <= 1'b0;
        end
    end

    assign hit = valid && (line == lookup_line);

endmodule

// File: rtl/eviction_write_buffer.sv
// rtl/eviction_write_buffer.sv - one-entry eviction write buffer between L1 and physical memory
module eviction_write_buffer #(
    parameter int LINE_WIDTH  = ewb_types_pkg::LINE_WIDTH,
    parameter int ADDR_WIDTH  = ewb_types_pkg::ADDR_WIDTH,
    parameter int OFFSET_BITS = ewb_types_pkg::OFFSET_BITS,
    parameter int DRAIN_DELAY = ewb_types_pkg::DRAIN_DELAY
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  cache_read,
    input  logic                  cache_write,
    input  logic [ADDR_WIDTH-1:0] cache_address,
    input  logic [LINE_WIDTH-1:0] cache_wdata,
    output logic                  cache_resp,
    output logic [LINE_WIDTH-1:0] cache_rdata,
    output logic                  pmem_read,
    output logic                  pmem_write,
    output logic [ADDR_WIDTH-1:0] pmem_address,
    output logic [LINE_WIDTH-1:0] pmem_wdata,
    input  logic                  pmem_resp,
    input  logic [LINE_WIDTH-1:0] pmem_rdata
);
    import ewb_types_pkg::*;

    localparam int LINE_ADDR_W = ADDR_WIDTH - OFFSET_BITS;
    localparam int CNT_W       = $clog2(DRAIN_DELAY + 2);
    localparam logic [CNT_W-1:0] DRAIN_CNT = CNT_W'(DRAIN_DELAY);

    ewb_state_t state, state_next;

    logic [LINE_ADDR_W-1:0] line_in;
    logic [LINE_ADDR_W-1:0] buf_line;
    logic [LINE_WIDTH-1:0]  buf_data;
    logic                   buf_valid;
    logic                   hit;
    logic [CNT_W-1:0]       idle_cnt;
    logic                   rd_req, wr_req;
    logic                   do_hit_read, do_capture, do_fill, do_clear;
    logic                   unused_offset;

    assign line_in       = cache_address[ADDR_WIDTH-1:OFFSET_BITS];
    assign unused_offset = ^cache_address[OFFSET_BITS-1:0];

    // The cycle in which cache_resp is high still sees the old request held; skip it.
    assign rd_req = cache_read  && !cache_resp;
    assign wr_req = cache_write && !cache_resp;

    ewb_entry #(
        .LINE_WIDTH  (LINE_WIDTH),
        .LINE_ADDR_W (LINE_ADDR_W)
    ) u_entry (
        .clk         (clk),
        .rst_n       (rst_n),
        .capture     (do_capture),
        .clear       (do_clear),
        .cap_line    (line_in),
        .cap_data    (cache_wdata),
        .lookup_line (line_in),
        .valid       (buf_valid),
        .line        (buf_line),
        .data        (buf_data),
        .hit         (hit)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: begin
                if (rd_req && hit)                            state_next = ST_IDLE;
                else if (wr_req && (!buf_valid || hit))       state_next = ST_IDLE;
                else if (rd_req)                              state_next = ST_MEM_READ;
                else if (wr_req)                              state_next = ST_MEM_WRITE;
                else if (buf_valid && idle_cnt == DRAIN_CNT)  state_next = ST_MEM_WRITE;
            end
            ST_MEM_READ:  if (pmem_resp) state_next = ST_COOLDOWN;
            ST_MEM_WRITE: if (pmem_resp) state_next = ST_COOLDOWN;
            default:      state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        do_hit_read = 1'b0;
        do_capture  = 1'b0;
        do_fill     = 1'b0;
        do_clear    = 1'b0;
        case (state)
            ST_IDLE: begin
                do_hit_read = rd_req && hit;
                do_capture  = !(rd_req && hit) && wr_req && (!buf_valid || hit);
            end
            ST_MEM_READ:  do_fill  = pmem_resp;
            ST_MEM_WRITE: do_clear = pmem_resp;
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cache_resp   <= 1'b0;
            cache_rdata  <= '0;
            pmem_read    <= 1'b0;
            pmem_write   <= 1'b0;
            pmem_address <= '0;
            pmem_wdata   <= '0;
            idle_cnt     <= '0;
        end else begin
            cache_resp <= do_hit_read || do_capture || do_fill;
            if (do_hit_read)  cache_rdata <= buf_data;
            else if (do_fill) cache_rdata <= pmem_rdata;

            pmem_read  <= (state_next == ST_MEM_READ);
            pmem_write <= (state_next == ST_MEM_WRITE);
            if (state == ST_IDLE && state_next == ST_MEM_READ)
                pmem_address <= {line_in, {OFFSET_BITS{1'b0}}};
            if (state == ST_IDLE && state_next == ST_MEM_WRITE) begin
                pmem_address <= {buf_line, {OFFSET_BITS{1'b0}}};
                pmem_wdata   <= buf_data;
            end

            // Counts quiet IDLE cycles only; any memory operation restarts the wait.
            if (state != ST_IDLE || do_capture)
                idle_cnt <= '0;
            else if (!rd_req && !wr_req && idle_cnt != DRAIN_CNT)
                idle_cnt <= idle_cnt + CNT_W'(1);
        end
    end

endmodule
